// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of the single-port VeriRISC memory: one whole
// transaction per grant (round-robin or fixed priority), with programmable read latency.
module mem_port_arbiter #(
    parameter int unsigned AW        = 5,
    parameter int unsigned DW        = 8,
    parameter int unsigned MEM_LAT   = 1,
    parameter int unsigned FIXED_PRI = 0
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_req0,
    input  logic          i_wr0,
    input  logic [AW-1:0] i_addr0,
    input  logic [DW-1:0] i_wdata0,
    output logic          o_ack0,
    output logic [DW-1:0] o_rdata0,
    input  logic          i_req1,
    input  logic          i_wr1,
    input  logic [AW-1:0] i_addr1,
    input  logic [DW-1:0] i_wdata1,
    output logic          o_ack1,
    output logic [DW-1:0] o_rdata1,
    output logic [AW-1:0] o_mem_addr,
    output logic [DW-1:0] o_mem_wdata,
    output logic          o_mem_rd,
    output logic          o_mem_wr,
    input  logic [DW-1:0] i_mem_rdata,
    output logic          o_busy,
    output logic          o_gnt_id
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_t;

    state_t        r_state;
    logic [2:0]    r_cnt;
    logic          r_last;
    logic          r_gnt;
    logic          r_busy;
    logic          r_ack0;
    logic          r_ack1;
    logic          r_mem_rd;
    logic          r_mem_wr;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;
    logic [DW-1:0] r_rdata0;
    logic [DW-1:0] r_rdata1;

    logic w_any;
    logic w_win;

    assign w_any = i_req0 | i_req1;

    // Tie break: fixed priority favours port 0, otherwise the port that did not win last.
    always_comb begin
        w_win = i_req1;
        if (i_req0 && i_req1) begin
            w_win = (FIXED_PRI != 0) ? 1'b0 : ~r_last;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_cnt       <= 3'd0;
            r_last      <= 1'b1;
            r_gnt       <= 1'b0;
            r_busy      <= 1'b0;
            r_ack0      <= 1'b0;
            r_ack1      <= 1'b0;
            r_mem_rd    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rdata0    <= '0;
            r_rdata1    <= '0;
        end else begin
            r_ack0   <= 1'b0;
            r_ack1   <= 1'b0;
            r_mem_rd <= 1'b0;
            r_mem_wr <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (w_any) begin
                        // mem_addr/mem_wdata/mem_wr double as the captured request.
                        r_gnt       <= w_win;
                        r_busy      <= 1'b1;
                        r_mem_addr  <= w_win ? i_addr1 : i_addr0;
                        r_mem_wdata <= w_win ? i_wdata1 : i_wdata0;
                        r_mem_wr    <= w_win ? i_wr1 : i_wr0;
                        r_mem_rd    <= w_win ? ~i_wr1 : ~i_wr0;
                        r_state     <= StIssue;
                    end
                end
                StIssue: begin
                    if (r_mem_wr) begin
                        r_ack0  <= ~r_gnt;
                        r_ack1  <= r_gnt;
                        r_state <= StResp;
                    end else begin
                        r_cnt   <= 3'(MEM_LAT);
                        r_state <= StWait;
                    end
                end
                StWait: begin
                    if (r_cnt == 3'd1) begin
                        if (r_gnt) begin
                            r_rdata1 <= i_mem_rdata;
                        end else begin
                            r_rdata0 <= i_mem_rdata;
                        end
                        r_ack0  <= ~r_gnt;
                        r_ack1  <= r_gnt;
                        r_cnt   <= 3'd0;
                        r_state <= StResp;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                StResp: begin
                    r_last  <= r_gnt;
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_ack0      = r_ack0;
    assign o_ack1      = r_ack1;
    assign o_rdata0    = r_rdata0;
    assign o_rdata1    = r_rdata1;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_mem_rd    = r_mem_rd;
    assign o_mem_wr    = r_mem_wr;
    assign o_busy      = r_busy;
    assign o_gnt_id    = r_gnt;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single-port VeriRISC program/data memory between two requesters: port 0 (CPU controller/datapath) and port 1 (program loader / debug DMA). Arbitrates whole transactions with a req/ack handshake and issues one memory read or write per grant. Waits a programmable read latency, then returns read data to the winning port. Sits between the CPU core, the loader and the memory macro.

Parameters:
AW, 5, address width in bits
DW, 8, data width in bits
MEM_LAT, 1, memory read latency in cycles from the mem_rd cycle to mem_rdata valid; legal range 1..4
FIXED_PRI, 0, 0 = round-robin between the ports; 1 = port 0 always wins a tie

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
req0  in  1  port 0 transaction request; held with wr0/addr0/wdata0 until ack0
wr0  in  1  port 0: 1 = write, 0 = read
addr0  in  AW  port 0 address
wdata0  in  DW  port 0 write data
ack0  out  1  port 0 one-cycle completion pulse
rdata0  out  DW  port 0 read data; valid with ack0 and held until the next port 0 read ack
req1, wr1, addr1, wdata1, ack1, rdata1  as for port 0, for port 1
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rd  out  1  memory read strobe, one cycle
mem_wr  out  1  memory write strobe, one cycle
mem_rdata  in  DW  memory read data
busy  out  1  high in every state except IDLE
gnt_id  out  1  port owning the current transaction; valid while busy

Behaviour:
- All outputs are driven from flops.
- Reset (async, rst=1):
  - state=IDLE; last_grant=1, so port 0 wins the first tie.
  - ack*, mem_rd, mem_wr, busy, gnt_id = 0; mem_addr, mem_wdata, rdata0, rdata1 = 0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - No req: stay.
  - Exactly one req: grant that port.
  - Both req: FIXED_PRI=1 grants port 0; FIXED_PRI=0 grants the port != last_grant.
  - On grant: capture winner's wr/addr/wdata into internal registers; set gnt_id; go to ISSUE.
- ISSUE (exactly 1 cycle):
  - mem_addr and mem_wdata are driven from the captured values.
  - mem_wr=1 if the captured wr=1, otherwise mem_rd=1.
  - Write goes to RESP. Read loads the latency counter with MEM_LAT and goes to WAIT.
- WAIT:
  - Counter decrements each cycle; on reaching 0, capture mem_rdata into the winner's rdata register and go to RESP.
  - Net effect: capture happens MEM_LAT cycles after the mem_rd cycle.
- RESP (1 cycle):
  - ack of the winner = 1.
  - last_grant = gnt_id, updated even when FIXED_PRI=1.
  - Next state IDLE.
- Latency from req sampled in IDLE to ack: 3 cycles for a write, 3+MEM_LAT cycles for a read. Minimum repeat interval per transaction is the same as this latency.
- Requester must deassert req in the cycle after ack. If req is still high in IDLE, it is treated as a new transaction.
- req or any request field changing after the grant is ignored; the transaction completes with the captured values and ack is still pulsed.
- The losing port's req stays pending and is granted in the next IDLE cycle. Under round-robin with both ports continuously requesting, grants alternate 0,1,0,1…
- rdata of the non-granted port never changes. Write transactions do not modify rdata.
- Reset mid-transaction aborts immediately. A pending strobe or ack drops asynchronously and no ack is issued for the aborted transaction.
- mem_rdata is only sampled in the final WAIT cycle.

Test Plan:
- Single read: mem[5]=8'hA7, MEM_LAT=1; req0 rd addr 5 -> mem_rd high for 1 cycle with mem_addr=5; ack0 pulses 4 cycles after req sampled, with rdata0=8'hA7; ack1 stays 0.
- Single write: req1 wr addr 31 data 8'h3C -> exactly one mem_wr cycle with mem_addr=31 and mem_wdata=8'h3C; ack1 pulses 3 cycles after req; rdata1 unchanged.
- Tie after reset with FIXED_PRI=0, both ports held requesting for 4 transactions -> grant order 0,1,0,1; busy high continuously except one IDLE cycle between transactions.
- FIXED_PRI=1, both ports continuously requesting -> port 0 granted every time; port 1 granted only in a cycle where req0=0.
- MEM_LAT=4 read with req0 dropped and addr0 changed the cycle after grant -> original address used, ack0 at cycle 7 with the correct data.
- rst pulsed during WAIT -> mem_rd, busy and ack go to 0 asynchronously, no ack for that transaction; a new req0 after reset completes normally.
